// File: rtl/axi_scratchpad_slave_if.sv
// axi_scratchpad_slave_if: AXI4 burst channels between the DMA master and the scratchpad slave
// aw*/w*/b* carry write bursts, ar*/r* carry read bursts; slave modport for the memory, master modport for the driver.
interface axi_scratchpad_slave_if #(parameter int ID_W = 4);
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awvalid;
    logic            awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_scratchpad_slave.sv
// axi_scratchpad_slave: AXI4 slave scratchpad, independent write and read burst FSMs over a dual-port word array
// clk: clock; rst: asynchronous active-low reset; axi: slave side of the AXI4 write (AW/W/B) and read (AR/R) channels.
module axi_scratchpad_slave #(
    parameter int ADDR_W = 8,
    parameter int ID_W   = 4
) (
    input logic clk,
    input logic rst,
    axi_scratchpad_slave_if.slave axi
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    localparam logic [ADDR_W-1:0] one_a = 1;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [31:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] wa, ra;
    logic [7:0] wlen, wcnt, rlen, rcnt;
    logic werr, wbad, rerr;
    logic [ID_W-1:0] bid, rid;
    logic [31:0] rdata;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_final, r_final;
    logic unused;
    assign unused = ^{axi.awaddr[31:ADDR_W+2], axi.awaddr[1:0], axi.araddr[31:ADDR_W+2], axi.araddr[1:0]};
    assign aw_hs   = axi.awvalid && axi.awready;
    assign w_hs    = axi.wvalid && axi.wready;
    assign b_hs    = axi.bvalid && axi.bready;
    assign ar_hs   = axi.arvalid && axi.arready;
    assign r_hs    = axi.rvalid && axi.rready;
    assign w_final = wcnt == wlen;
    assign r_final = rcnt == rlen;
    assign axi.awready = w_state == W_IDLE;
    assign axi.wready  = w_state == W_DATA;
    assign axi.bvalid  = w_state == W_RESP;
    assign axi.bid     = bid;
    assign axi.bresp   = axi.bvalid ? {werr | wbad, 1'b0} : 2'b00;
    assign axi.arready = r_state == R_IDLE;
    assign axi.rvalid  = r_state == R_DATA;
    assign axi.rid     = rid;
    assign axi.rdata   = rdata;
    assign axi.rresp   = axi.rvalid ? {rerr, 1'b0} : 2'b00;
    assign axi.rlast   = axi.rvalid && r_final;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end
    always_comb begin
        w_next = w_state;
        w_next = w_state == W_IDLE ? (aw_hs ? W_DATA : W_IDLE) :
                 w_state == W_DATA ? (w_hs && w_final ? W_RESP : W_DATA) :
                                     (b_hs ? W_IDLE : W_RESP);
        r_next = r_state;
        r_next = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) :
                                     (r_hs && r_final ? R_IDLE : R_DATA);
    end
    // The burst always ends on the counted beat; a misplaced wlast only poisons the response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wa   <= '0;
            wlen <= '0;
            wcnt <= '0;
            bid  <= '0;
            werr <= 1'b0;
            wbad <= 1'b0;
        end else if (aw_hs) begin
            wa   <= axi.awaddr[ADDR_W+1:2];
            wlen <= axi.awlen;
            wcnt <= '0;
            bid  <= axi.awid;
            werr <= axi.awsize != 3'b010 || axi.awburst != 2'b01;
            wbad <= 1'b0;
        end else if (w_hs) begin
            wa   <= wa + one_a;
            wcnt <= wcnt + 8'd1;
            if (axi.wlast != w_final) wbad <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (w_hs && !werr)
            for (int b = 0; b < 4; b++)
                if (axi.wstrb[b]) mem[wa][8*b +: 8] <= axi.wdata[8*b +: 8];
    end
    // ra always points at the word to present after the current beat handshakes.
    // Registered reads sample the array before a same-edge write lands (read-before-write).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ra    <= '0;
            rlen  <= '0;
            rcnt  <= '0;
            rid   <= '0;
            rerr  <= 1'b0;
            rdata <= '0;
        end else if (ar_hs) begin
            ra    <= axi.araddr[ADDR_W+1:2] + one_a;
            rlen  <= axi.arlen;
            rcnt  <= '0;
            rid   <= axi.arid;
            rerr  <= axi.arsize != 3'b010 || axi.arburst != 2'b01;
            rdata <= (axi.arsize != 3'b010 || axi.arburst != 2'b01) ? 32'd0 : mem[axi.araddr[ADDR_W+1:2]];
        end else if (r_hs) begin
            ra    <= ra + one_a;
            rcnt  <= rcnt + 8'd1;
            rdata <= rerr ? 32'd0 : mem[ra];
        end
    end
endmodule

// File: tb/tb_axi_scratchpad_slave.sv
// tb_axi_scratchpad_slave: randomized bursts against a word-array reference model of the scratchpad
module tb_axi_scratchpad_slave;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [31:0] model [256];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    axi_scratchpad_slave_if #(.ID_W(4)) axi();
    axi_scratchpad_slave #(.ADDR_W(8), .ID_W(4)) dut (.clk(clk), .rst(rst), .axi(axi));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic fill(input int len, input bit rnd_strb);
        for (int i = 0; i <= len; i++) begin
            wd[i] = $urandom;
            ws[i] = rnd_strb ? 4'($urandom_range(0, 15)) : 4'hf;
        end
    endtask
    // stop: beat index at which reset is asserted (-1 none); bad_beat: beat whose wlast is inverted (-1 none)
    task automatic wr(input logic [31:0] addr, input int len, input logic [2:0] size, input logic [1:0] burst,
                      input logic [3:0] id, input int stop, input bit lat, input int bad_beat);
        bit err, bad;
        int t, hs;
        logic [7:0] a;
        err = !(size == 3'b010 && burst == 2'b01);
        bad = 0;
        a = addr[9:2];
        axi.awaddr = addr; axi.awlen = 8'(len); axi.awsize = size; axi.awburst = burst; axi.awid = id;
        axi.awvalid = 1;
        t = 0;
        while (!axi.awready && t < 100) begin step(); t++; end
        chk("aw_wait", 64'(t < 100), 1);
        step();
        axi.awvalid = 0;
        hs = cyc - 1;
        for (int i = 0; i <= len; i++) begin
            if (i == stop) begin
                rst = 0;
                #1;
                chk("abort_bvalid", axi.bvalid, 0);
                chk("abort_awready", axi.awready, 1);
                chk("abort_wready", axi.wready, 0);
                axi.wvalid = 0;
                @(negedge clk) rst = 1;
                step();
                return;
            end
            if (!lat && $urandom_range(0, 3) == 0) begin axi.wvalid = 0; step(); end
            axi.wdata = wd[i]; axi.wstrb = ws[i];
            axi.wlast = (i == len) ^ (i == bad_beat);
            if (i == bad_beat) bad = 1;
            axi.wvalid = 1;
            t = 0;
            while (!axi.wready && t < 100) begin step(); t++; end
            chk("w_wait", 64'(t < 100), 1);
            step();
            if (!err)
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model[a][8*b +: 8] = wd[i][8*b +: 8];
            a++;
        end
        axi.wvalid = 0; axi.wlast = 0;
        if (lat) begin
            chk("b_lat_valid", axi.bvalid, 1);
            chk("b_latency", cyc - hs, len + 2);
        end else repeat ($urandom_range(0, 2)) step();
        t = 0;
        while (!axi.bvalid && t < 100) begin step(); t++; end
        chk("b_wait", 64'(t < 100), 1);
        chk("b_resp", axi.bresp, (err || bad) ? 2'b10 : 2'b00);
        chk("b_id", axi.bid, id);
        axi.bready = 1;
        step();
        axi.bready = 0;
        chk("b_done_bvalid", axi.bvalid, 0);
        chk("b_done_awready", axi.awready, 1);
    endtask
    task automatic rd(input logic [31:0] addr, input int len, input logic [2:0] size, input logic [1:0] burst,
                      input logic [3:0] id, input bit pat);
        bit err, stall;
        int t, beat, k;
        logic [7:0] a;
        logic [34:0] held;
        logic [4:0] p;
        p = 5'b11001;
        err = !(size == 3'b010 && burst == 2'b01);
        a = addr[9:2];
        stall = 0; beat = 0; k = 0; held = '0;
        axi.araddr = addr; axi.arlen = 8'(len); axi.arsize = size; axi.arburst = burst; axi.arid = id;
        axi.arvalid = 1;
        t = 0;
        while (!axi.arready && t < 100) begin step(); t++; end
        chk("ar_wait", 64'(t < 100), 1);
        step();
        axi.arvalid = 0;
        chk("r_first_valid", axi.rvalid, 1);
        t = 0;
        while (beat <= len && t < 400) begin
            axi.rready = pat ? (k < 5 ? p[k] : 1'b1) : 1'($urandom_range(0, 1));
            k++;
            if (axi.rvalid) begin
                if (stall) chk("r_hold", {axi.rlast, axi.rresp, axi.rdata}, held);
                if (axi.rready) begin
                    chk("r_data", axi.rdata, err ? 32'd0 : model[a]);
                    chk("r_last", axi.rlast, beat == len);
                    chk("r_resp", axi.rresp, err ? 2'b10 : 2'b00);
                    chk("r_id", axi.rid, id);
                    beat++;
                    a++;
                    stall = 0;
                end else begin
                    stall = 1;
                    held = {axi.rlast, axi.rresp, axi.rdata};
                end
            end
            step();
            t++;
        end
        chk("r_beats", beat, len + 1);
        axi.rready = 0;
        chk("r_done_rvalid", axi.rvalid, 0);
        chk("r_done_arready", axi.arready, 1);
    endtask
    initial begin
        logic [31:0] ad;
        logic [2:0] sz;
        logic [1:0] bu;
        int ln;
        axi.awid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0; axi.awvalid = 0;
        axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.wvalid = 0; axi.bready = 0;
        axi.arid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0; axi.arvalid = 0;
        axi.rready = 0;
        repeat (3) step();
        chk("rst_awready", axi.awready, 1);
        chk("rst_arready", axi.arready, 1);
        chk("rst_wready", axi.wready, 0);
        chk("rst_bvalid", axi.bvalid, 0);
        chk("rst_rvalid", axi.rvalid, 0);
        chk("rst_rlast", axi.rlast, 0);
        chk("rst_resp", {axi.bresp, axi.rresp}, 0);
        chk("rst_rdata", axi.rdata, 0);
        chk("rst_ids", {axi.bid, axi.rid}, 0);
        @(negedge clk) rst = 1;
        step();
        fill(255, 0);
        wr(32'h0, 255, 3'b010, 2'b01, 4'h3, -1, 0, -1);
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hf; end
        wr(32'h10, 3, 3'b010, 2'b01, 4'h5, -1, 1, -1);
        rd(32'h10, 3, 3'b010, 2'b01, 4'h5, 0);
        wd[0] = 32'h11223344; ws[0] = 4'hf;
        wr(32'h40, 0, 3'b010, 2'b01, 4'h1, -1, 0, -1);
        wd[0] = 32'hDEADBEEF; ws[0] = 4'b0011;
        wr(32'h40, 0, 3'b010, 2'b01, 4'h2, -1, 0, -1);
        rd(32'h40, 0, 3'b010, 2'b01, 4'h2, 0);
        fill(1, 0);
        wr(32'h80, 1, 3'b100, 2'b01, 4'h7, -1, 0, -1);
        rd(32'h80, 1, 3'b010, 2'b01, 4'h7, 0);
        rd(32'h80, 0, 3'b010, 2'b00, 4'h8, 0);
        fill(1, 0);
        wr(32'h3FC, 1, 3'b010, 2'b01, 4'hA, -1, 0, -1);
        rd(32'h3FC, 1, 3'b010, 2'b01, 4'hA, 0);
        rd(32'h0, 0, 3'b010, 2'b01, 4'hB, 0);
        rd(32'h10, 2, 3'b010, 2'b01, 4'h9, 1);
        fill(3, 1);
        wr(32'h20, 3, 3'b010, 2'b01, 4'hC, -1, 0, 1);
        fill(2, 1);
        wr(32'h30, 2, 3'b010, 2'b01, 4'hD, -1, 0, 2);
        rd(32'h20, 7, 3'b010, 2'b01, 4'hC, 0);
        fill(3, 0);
        wr(32'h60, 3, 3'b010, 2'b01, 4'h2, 2, 0, -1);
        rd(32'h60, 3, 3'b010, 2'b01, 4'h4, 0);
        fill(3, 0);
        wr(32'h60, 3, 3'b010, 2'b01, 4'h6, -1, 0, -1);
        rd(32'h60, 3, 3'b010, 2'b01, 4'h6, 0);
        repeat (25) begin
            ln = $urandom_range(0, 15);
            ad = $urandom;
            sz = $urandom_range(0, 4) == 0 ? 3'($urandom_range(0, 7)) : 3'b010;
            bu = $urandom_range(0, 4) == 0 ? 2'($urandom_range(0, 3)) : 2'b01;
            fill(ln, 1);
            wr(ad, ln, sz, bu, 4'($urandom_range(0, 15)), -1, 0, $urandom_range(0, 5) == 0 ? ln : -1);
            sz = $urandom_range(0, 4) == 0 ? 3'($urandom_range(0, 7)) : 3'b010;
            rd(ad, $urandom_range(0, 15), sz, 2'b01, 4'($urandom_range(0, 15)), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
